// File: rtl/audio_dac_serializer.sv
// Stereo sample FIFO feeding a left-justified DAC serializer, one pair per FRAME_LEN-clock frame.
// Latency: a queued pair loads at the next frame boundary and its MSB appears one clock later.
// Backpressure: in_ready is low while the frame FIFO is full. Optional AUDIO_DAC_HOLD_ON_UNDERRUN_EN.
module audio_dac_serializer #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 250,
    parameter int FIFO_AW   = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_left,
    input  logic [DATA_W-1:0]   in_right,
    output logic                aud_daclrck,
    output logic                aud_dacdat,
    output logic [FIFO_AW:0]    fifo_level,
    output logic                underrun,
    output logic [15:0]         underrun_count
);

    typedef struct packed {
        logic [DATA_W-1:0] left;
        logic [DATA_W-1:0] right;
    } pair_t;

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_HALF   = CNT_W'(FRAME_LEN / 2);
    localparam logic [CNT_W-1:0]   L_END      = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]   R_END      = CNT_W'(FRAME_LEN / 2 + DATA_W);
    localparam logic [FIFO_AW:0]   LEVEL_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);

    pair_t              mem [DEPTH];
    pair_t              push_dat;
    pair_t              head_dat;
    pair_t              load_dat;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   level_nxt;
    logic               fifo_empty;
    logic               push_vld;
    logic               load_vld;
    logic               pop_vld;

    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  left_sr;
    logic [DATA_W-1:0]  right_sr;

    assign push_dat   = '{left: in_left, right: in_right};
    assign head_dat   = mem[rd_ptr];
    assign fifo_empty = (fifo_level == '0);
    assign push_vld   = in_valid && in_ready;
    assign load_vld   = enable && (cnt == CNT_LAST);
    // A load against an empty FIFO is an underrun even if a push lands in the same cycle.
    assign pop_vld    = load_vld && !fifo_empty;

    always_comb begin
        level_nxt = fifo_level;
        if (push_vld && !pop_vld) begin
            level_nxt = fifo_level + LEVEL_ONE;
        end else if (pop_vld && !push_vld) begin
            level_nxt = fifo_level - LEVEL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            in_ready   <= 1'b0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_vld) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            fifo_level <= level_nxt;
            in_ready   <= (level_nxt != LEVEL_FULL);
        end
    end

`ifdef AUDIO_DAC_HOLD_ON_UNDERRUN_EN
    // Last pair actually popped; replayed whenever a frame finds the FIFO empty.
    pair_t held_dat;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            held_dat <= '0;
        end else if (pop_vld) begin
            held_dat <= head_dat;
        end
    end

    assign load_dat = pop_vld ? head_dat : held_dat;
`else
    assign load_dat = pop_vld ? head_dat : '0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else begin
            underrun <= load_vld && fifo_empty;
            if (load_vld && fifo_empty && (underrun_count != 16'hFFFF)) begin
                underrun_count <= underrun_count + 16'd1;
            end
        end
    end

    // Outputs are registered from the pre-edge counter, so value k appears one clock after cnt==k.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt         <= CNT_LAST;
            left_sr     <= '0;
            right_sr    <= '0;
            aud_daclrck <= 1'b0;
            aud_dacdat  <= 1'b0;
        end else if (!enable) begin
            cnt         <= CNT_LAST;
            aud_daclrck <= 1'b0;
            aud_dacdat  <= 1'b0;
        end else begin
            aud_daclrck <= (cnt < CNT_HALF);
            aud_dacdat  <= 1'b0;
            if (load_vld) begin
                cnt      <= '0;
                left_sr  <= load_dat.left;
                right_sr <= load_dat.right;
            end else begin
                cnt <= cnt + CNT_ONE;
                if (cnt < L_END) begin
                    aud_dacdat <= left_sr[DATA_W-1];
                    left_sr    <= left_sr << 1;
                end else if ((cnt >= CNT_HALF) && (cnt < R_END)) begin
                    aud_dacdat <= right_sr[DATA_W-1];
                    right_sr   <= right_sr << 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer: table of sample pairs plus hand-written corner sequences.
module tb_audio_dac_serializer;

    localparam int FRAME = 250;
    localparam int HALF  = FRAME / 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_left;
    logic [15:0] in_right;
    logic        aud_daclrck;
    logic        aud_dacdat;
    logic [4:0]  fifo_level;
    logic        underrun;
    logic [15:0] underrun_count;

    int total = 0;
    int bad   = 0;

    audio_dac_serializer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_left        (in_left),
        .in_right       (in_right),
        .aud_daclrck    (aud_daclrck),
        .aud_dacdat     (aud_dacdat),
        .fifo_level     (fifo_level),
        .underrun       (underrun),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] left;
        logic [15:0] right;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        enable   = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        in_left  = l;
        in_right = r;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Starts at (or waits for) the first high-lrck sample, returns one frame later at the next frame's first sample.
    task automatic capture_frame(output logic [15:0] l, output logic [15:0] r,
                                 output int waited, output int lrck_ok, output int stray);
        l = '0; r = '0; waited = 0; lrck_ok = 0; stray = 0;
        while (aud_daclrck !== 1'b1 && waited < 2 * FRAME) begin
            tick();
            waited++;
        end
        check("frame_start", 32'(aud_daclrck), 32'd1);
        for (int k = 0; k < FRAME; k++) begin
            if (k < HALF && aud_daclrck === 1'b1) lrck_ok++;
            if (k >= HALF && aud_daclrck === 1'b0) lrck_ok++;
            if (k < 16) l = {l[14:0], aud_dacdat};
            else if (k >= HALF && k < HALF + 16) r = {r[14:0], aud_dacdat};
            else if (aud_dacdat !== 1'b0) stray++;
            tick();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[5];
        logic [15:0] l, r, hold_l, hold_r;
        int          waited, lrck_ok, stray, n, first, last, accepted;

        vecs[0] = '{16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE};
        vecs[1] = '{16'hA5C3, 16'h5A3C, 16'hA5C3, 16'h5A3C};
        vecs[2] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
        vecs[3] = '{16'h0001, 16'h8000, 16'h0001, 16'h8000};
        vecs[4] = '{16'h1234, 16'hFEDC, 16'h1234, 16'hFEDC};
`ifdef AUDIO_DAC_HOLD_ON_UNDERRUN_EN
        hold_l = 16'h1234;
        hold_r = 16'hFEDC;
`else
        hold_l = 16'h0000;
        hold_r = 16'h0000;
`endif

        reset_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_left = '0; in_right = '0;
        repeat (3) tick();
        check("rst_lrck", 32'(aud_daclrck), 32'd0);
        check("rst_dat", 32'(aud_dacdat), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_count", 32'(underrun_count), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        reset_n = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Table: queue all pairs while disabled, then play them out in order.
        for (int i = 0; i < 5; i++) push_pair(vecs[i].left, vecs[i].right);
        check("tbl_level", 32'(fifo_level), 32'd5);
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            capture_frame(l, r, waited, lrck_ok, stray);
            check($sformatf("tbl%0d_left", i), 32'(l), 32'(vecs[i].exp_l));
            check($sformatf("tbl%0d_right", i), 32'(r), 32'(vecs[i].exp_r));
            check($sformatf("tbl%0d_lrck", i), lrck_ok, FRAME);
            check($sformatf("tbl%0d_stray", i), stray, 0);
            check($sformatf("tbl%0d_wait", i), waited, (i == 0) ? 2 : 0);
        end
        capture_frame(l, r, waited, lrck_ok, stray);
        check("hold_left", 32'(l), 32'(hold_l));
        check("hold_right", 32'(r), 32'(hold_r));
        check("tbl_underruns", 32'(underrun_count), 32'd2);
        enable = 1'b0;
        tick();
        check("disabled_lrck", 32'(aud_daclrck), 32'd0);

        // Underrun: three empty frames, one-cycle pulses 250 clocks apart.
        do_reset();
        enable = 1'b1;
        n = 0; first = -1; last = -1; stray = 0;
        for (int i = 1; i <= 3 * FRAME; i++) begin
            tick();
            if (underrun === 1'b1) begin
                n++;
                if (first < 0) first = i;
                last = i;
            end
            if (aud_dacdat !== 1'b0) stray++;
        end
        check("ur_pulses", n, 3);
        check("ur_first", first, 1);
        check("ur_last", last, 1 + 2 * FRAME);
        check("ur_count", 32'(underrun_count), 32'd3);
        check("ur_dat_zero", stray, 0);
        enable = 1'b0;

        // Push on the load cycle with one pair queued.
        do_reset();
        push_pair(16'h1111, 16'h2222);
        in_left = 16'h3333; in_right = 16'h4444; in_valid = 1'b1; enable = 1'b1;
        tick();
        in_valid = 1'b0;
        check("pp1_level", 32'(fifo_level), 32'd1);
        check("pp1_underrun", 32'(underrun), 32'd0);
        capture_frame(l, r, waited, lrck_ok, stray);
        check("pp1_f0", {l, r}, 32'h1111_2222);
        check("pp1_wait", waited, 1);
        capture_frame(l, r, waited, lrck_ok, stray);
        check("pp1_f1", {l, r}, 32'h3333_4444);
        enable = 1'b0;

        // Push on the load cycle with an empty FIFO.
        do_reset();
        in_left = 16'h5555; in_right = 16'h6666; in_valid = 1'b1; enable = 1'b1;
        tick();
        in_valid = 1'b0;
        check("pp0_underrun", 32'(underrun), 32'd1);
        check("pp0_level", 32'(fifo_level), 32'd1);
        capture_frame(l, r, waited, lrck_ok, stray);
        check("pp0_f0", {l, r}, 32'h0000_0000);
        capture_frame(l, r, waited, lrck_ok, stray);
        check("pp0_f1", {l, r}, 32'h5555_6666);
        check("pp0_level_end", 32'(fifo_level), 32'd0);
        enable = 1'b0;

        // Backpressure: 20 offered back-to-back, 16 accepted, then one slot per frame.
        do_reset();
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            in_left = 16'h1000 + 16'(i); in_right = 16'h2000 + 16'(i); in_valid = 1'b1;
            if (in_ready === 1'b1) accepted++;
            tick();
        end
        check("bp_accepted", accepted, 16);
        check("bp_level", 32'(fifo_level), 32'd16);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        in_left = 16'h1010; in_right = 16'h2010; enable = 1'b1;
        tick();
        check("bp_free_ready", 32'(in_ready), 32'd1);
        check("bp_free_level", 32'(fifo_level), 32'd15);
        tick();
        in_valid = 1'b0;
        check("bp_refill_level", 32'(fifo_level), 32'd16);
        check("bp_refill_ready", 32'(in_ready), 32'd0);
        n = 0;
        for (int f = 0; f <= 16; f++) begin
            capture_frame(l, r, waited, lrck_ok, stray);
            if (l !== 16'h1000 + 16'(f) || r !== 16'h2000 + 16'(f)) n++;
        end
        check("bp_order_errors", n, 0);
        enable = 1'b0;

        // Reset at cnt=60 with five frames queued and a nonzero underrun count.
        do_reset();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) push_pair(16'hC000 + 16'(i), 16'h0C00 + 16'(i));
        enable = 1'b1;
        tick();
        tick();
        check("mr_level", 32'(fifo_level), 32'd5);
        check("mr_count", 32'(underrun_count), 32'd1);
        repeat (59) tick();
        check("mr_lrck_before", 32'(aud_daclrck), 32'd1);
        reset_n = 1'b0;
        tick();
        check("mr_lrck", 32'(aud_daclrck), 32'd0);
        check("mr_dat", 32'(aud_dacdat), 32'd0);
        check("mr_level0", 32'(fifo_level), 32'd0);
        check("mr_count0", 32'(underrun_count), 32'd0);
        check("mr_in_ready", 32'(in_ready), 32'd0);
        reset_n = 1'b1;
        enable  = 1'b0;
        tick();

        // Saturation: preload the counter near the top, then run three underruns.
        do_reset();
        force dut.underrun_count = 16'hFFFD;
        #1;
        release dut.underrun_count;
        if (underrun_count === 16'hFFFD) begin
            enable = 1'b1;
            tick();
            check("sat_pulse0", 32'(underrun), 32'd1);
            check("sat_count0", 32'(underrun_count), 32'h0000_FFFE);
            repeat (FRAME) tick();
            check("sat_pulse1", 32'(underrun), 32'd1);
            check("sat_count1", 32'(underrun_count), 32'h0000_FFFF);
            repeat (FRAME) tick();
            check("sat_pulse2", 32'(underrun), 32'd1);
            check("sat_count2", 32'(underrun_count), 32'h0000_FFFF);
            enable = 1'b0;
        end else begin
            $display("note: counter preload not taken, saturation sequence skipped");
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
